// File: rtl/ex_wb_flag_stage.sv
// ex_wb_flag_stage: 2-entry EX->WB elastic buffer owning EFLAGS with CF/AF forwarding
module ex_wb_flag_stage #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] EFLAGS_RST = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_flags,
    input  logic [31:0] ex_flag_mask,
    input  logic [2:0]  ex_dest,
    input  logic [1:0]  ex_datasize,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_result,
    output logic [2:0]  wb_dest,
    output logic [1:0]  wb_datasize,
    output logic [31:0] eflags,
    output logic        cf_fwd,
    output logic        af_fwd
);
    logic [31:0] res_q [DEPTH];
    logic [31:0] flg_q [DEPTH];
    logic [31:0] msk_q [DEPTH];
    logic [2:0]  dst_q [DEPTH];
    logic [1:0]  dsz_q [DEPTH];
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q, head_d, tail_q, tail_d;
    logic [31:0] eflags_q, eflags_d;
    logic        enq, deq, young, y_cf, h_cf, y_af, h_af;

    assign ex_ready    = cnt_q != 2'd2;
    assign wb_valid    = cnt_q != 2'd0;
    assign enq         = ex_valid & ex_ready & ~flush;
    assign deq         = wb_valid & wb_ready & ~flush;
    assign wb_result   = res_q[head_q];
    assign wb_dest     = dst_q[head_q];
    assign wb_datasize = dsz_q[head_q];
    assign eflags      = eflags_q;
    assign young       = ~tail_q;

    // Pointer/count advance and masked EFLAGS commit of the retiring head
    always_comb begin
        cnt_d    = flush ? 2'd0 : cnt_q + {1'b0, enq} - {1'b0, deq};
        head_d   = flush ? 1'b0 : head_q ^ deq;
        tail_d   = flush ? 1'b0 : tail_q ^ enq;
        eflags_d = deq ? ((((eflags_q & ~msk_q[head_q]) | (flg_q[head_q] & msk_q[head_q]))
                   & 32'h003F_FFFF) | 32'h0000_0002) : eflags_q;
    end

    // Youngest in-flight writer of CF/AF wins, falling back to architectural EFLAGS
    always_comb begin
        y_cf   = (cnt_q == 2'd2) & msk_q[young][0];
        h_cf   = wb_valid & msk_q[head_q][0];
        y_af   = (cnt_q == 2'd2) & msk_q[young][4];
        h_af   = wb_valid & msk_q[head_q][4];
        cf_fwd = y_cf ? flg_q[young][0] : h_cf ? flg_q[head_q][0] : eflags_q[0];
        af_fwd = y_af ? flg_q[young][4] : h_af ? flg_q[head_q][4] : eflags_q[4];
    end

    // Control state and EFLAGS register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            eflags_q <= EFLAGS_RST;
        end else begin
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            eflags_q <= eflags_d;
        end
    end

    // Entry storage written at tail on accepted enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
                msk_q[i] <= '0;
                dst_q[i] <= '0;
                dsz_q[i] <= '0;
            end
        end else if (enq) begin
            res_q[tail_q] <= ex_alu_out;
            flg_q[tail_q] <= ex_flags;
            msk_q[tail_q] <= ex_flag_mask;
            dst_q[tail_q] <= ex_dest;
            dsz_q[tail_q] <= ex_datasize;
        end
    end
endmodule
